usrt_apb_ctrl: RTL and testbench

APB-side controller that schedules traffic between the APB bus and the UART TX/RX cores. It buffers transmit bytes in a TX FIFO and feeds them to the TX core one frame at a time. It queues received bytes in an RX FIFO. It exposes data, status and control registers. It replaces the direct APB-to-core coupling in `top`, and stalls the bus only when a FIFO cannot service the access.

---
 rtl/usrt_apb_ctrl.sv | 168 ++++++++++++++++
 tb/tb_usrt_apb_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_apb_ctrl.sv
// APB-side UART controller: TX/RX byte FIFOs, register file and a TX frame scheduler.
// The APB bus is stalled only when a DATA access cannot be serviced by its FIFO.
module usrt_apb_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_Pclk,
    input  logic       i_Presetn,
    input  logic [1:0] i_Paddr,
    input  logic       i_Psel,
    input  logic       i_Penable,
    input  logic       i_Pwrite,
    input  logic [7:0] i_Pwdata,
    output logic [7:0] o_Prdata,
    output logic       o_Pready,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    input  logic       i_Tx_Done,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_STATUS = 2'd1,
        ADDR_CTRL   = 2'd2,
        ADDR_CLR    = 2'd3
    } reg_addr_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } tx_state_e;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic          tx_en_q, tx_en_d, rx_en_q, rx_en_d;
    logic          rx_ovr_q, rx_ovr_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    tx_state_e     state_q, state_d;

    reg_addr_e     addr;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          apb_access, data_sel, stall, apb_wr, apb_rd;
    logic          tx_push, tx_launch, rx_push, rx_pop;
    logic          ctrl_wr, clr_wr, ovr_set;
    logic [7:0]    status;

    assign addr     = reg_addr_e'(i_Paddr);
    assign tx_full  = (tx_count_q == FULL_CNT);
    assign tx_empty = (tx_count_q == '0);
    assign rx_full  = (rx_count_q == FULL_CNT);
    assign rx_empty = (rx_count_q == '0);

    // Stall decisions use the pre-edge FIFO counts only.
    assign apb_access = i_Psel & i_Penable;
    assign data_sel   = (addr == ADDR_DATA);
    assign stall      = apb_access & data_sel & (i_Pwrite ? tx_full : rx_empty);
    assign o_Pready   = apb_access & ~stall;
    assign apb_wr     = o_Pready & i_Pwrite;
    assign apb_rd     = o_Pready & ~i_Pwrite;

    assign tx_push = apb_wr & data_sel;
    assign rx_pop  = apb_rd & data_sel;
    assign ctrl_wr = apb_wr & (addr == ADDR_CTRL);
    assign clr_wr  = apb_wr & (addr == ADDR_CLR) & i_Pwdata[4];

    // A full RX FIFO still accepts a byte when a DATA read frees a slot on the same edge.
    assign rx_push = i_Rx_DV & rx_en_q & (~rx_full | rx_pop);
    assign ovr_set = i_Rx_DV & rx_en_q & rx_full & ~rx_pop;

    assign status = {2'b00, (state_q != S_IDLE), rx_ovr_q, rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        state_d   = state_q;
        tx_launch = 1'b0;
        unique case (state_q)
            S_IDLE: if (tx_en_q && !tx_empty) begin
                tx_launch = 1'b1;
                state_d   = S_BUSY;
            end
            S_BUSY: if (i_Tx_Done) state_d = S_IDLE;
        endcase
    end

    // The launch cycle presents the FIFO head directly; afterwards the latched copy holds it.
    assign o_Tx_DV   = tx_launch;
    assign o_Tx_Byte = tx_launch ? tx_mem_q[tx_rd_ptr_q] : tx_byte_q;

    always_comb begin
        o_Prdata = 8'h00;
        if (apb_rd) begin
            unique case (addr)
                ADDR_DATA:   o_Prdata = rx_mem_q[rx_rd_ptr_q];
                ADDR_STATUS: o_Prdata = status;
                ADDR_CTRL:   o_Prdata = {6'b0, rx_en_q, tx_en_q};
                ADDR_CLR:    o_Prdata = 8'h00;
            endcase
        end
    end

    // NOTE: next-state logic uses blocking '=' with defaults first so no latch is inferred;
    // the state registers below use non-blocking '<=' only.
    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        tx_en_d     = tx_en_q;
        rx_en_d     = rx_en_q;
        rx_ovr_d    = rx_ovr_q;
        tx_byte_d   = tx_byte_q;
        if (tx_push)   tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
        if (tx_launch) tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
        if (rx_push)   rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
        if (rx_pop)    rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
        tx_count_d = tx_count_q + CW'(tx_push) - CW'(tx_launch);
        rx_count_d = rx_count_q + CW'(rx_push) - CW'(rx_pop);
        if (ctrl_wr) begin
            tx_en_d = i_Pwdata[0];
            rx_en_d = i_Pwdata[1];
        end
        if (clr_wr)    rx_ovr_d  = 1'b0;
        if (ovr_set)   rx_ovr_d  = 1'b1;
        if (tx_launch) tx_byte_d = tx_mem_q[tx_rd_ptr_q];
    end

    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            state_q     <= S_IDLE;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            rx_count_q  <= '0;
            tx_en_q     <= 1'b1;
            rx_en_q     <= 1'b1;
            rx_ovr_q    <= 1'b0;
            tx_byte_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            rx_count_q  <= rx_count_d;
            tx_en_q     <= tx_en_d;
            rx_en_q     <= rx_en_d;
            rx_ovr_q    <= rx_ovr_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; pointers and counts define which entries are valid.
    always_ff @(posedge i_Pclk) begin
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= i_Pwdata;
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= i_Rx_Byte;
    end

endmodule

// File: tb/tb_usrt_apb_ctrl.sv
// Scoreboard bench for usrt_apb_ctrl: stimulus pushes expected reads and TX bytes into
// queues; monitors pop and compare whenever the DUT completes a read or launches a frame.
module tb_usrt_apb_ctrl;

    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] i_Paddr;
    logic       i_Psel, i_Penable, i_Pwrite;
    logic [7:0] i_Pwdata;
    logic [7:0] o_Prdata;
    logic       o_Pready;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Byte;
    logic       i_Tx_Done;
    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;

    usrt_apb_ctrl #(.FIFO_DEPTH(FD)) dut (
        .i_Pclk    (clk),
        .i_Presetn (rst_n),
        .i_Paddr   (i_Paddr),
        .i_Psel    (i_Psel),
        .i_Penable (i_Penable),
        .i_Pwrite  (i_Pwrite),
        .i_Pwdata  (i_Pwdata),
        .o_Prdata  (o_Prdata),
        .o_Pready  (o_Pready),
        .o_Tx_DV   (o_Tx_DV),
        .o_Tx_Byte (o_Tx_Byte),
        .i_Tx_Done (i_Tx_Done),
        .i_Rx_DV   (i_Rx_DV),
        .i_Rx_Byte (i_Rx_Byte)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_model[$];
    bit         ovr_model = 1'b0;
    bit         rx_en_model = 1'b1;

    int tx_hold = 1;
    bit tx_block = 1'b0;
    int epoch = 0;
    int tx_launch_cnt = 0;
    int tx_done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [7:0] exp_status(input bit txf, input bit txe, input bit busy);
        return {2'b00, busy, ovr_model, rx_model.size() == FD, rx_model.size() == 0, txe, txf};
    endfunction

    // Read monitor: compares every completed APB read against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && i_Psel && i_Penable && o_Pready && !i_Pwrite) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read", o_Prdata);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check(e.name, o_Prdata, e.exp);
            end
        end
    end

    // TX monitor: every launch must carry the next byte written to DATA.
    always @(negedge clk) begin
        if (rst_n && o_Tx_DV) begin
            tx_launch_cnt++;
            if (tx_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected: got 0x%0h expected no launch", o_Tx_Byte);
            end else begin
                logic [7:0] e;
                e = tx_q.pop_front();
                check("tx_byte", o_Tx_Byte, e);
            end
        end
    end

    // TX core model: holds the frame for tx_hold cycles (or while blocked), then pulses done.
    initial begin
        i_Tx_Done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && o_Tx_DV) begin
                logic [7:0] lat;
                int         ep;
                lat = o_Tx_Byte;
                ep  = epoch;
                for (int i = 0; i < 3000 && (tx_block || i < tx_hold); i++) @(posedge clk);
                @(posedge clk);
                #1;
                if (ep == epoch) check("tx_byte_stable", o_Tx_Byte, lat);
                i_Tx_Done = 1'b1;
                @(posedge clk);
                #1;
                i_Tx_Done = 1'b0;
                tx_done_cnt++;
            end
        end
    end

    task automatic wait_ready(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (o_Pready) return;
        end
        timeout_fail(name);
    endtask

    task automatic apb_xfer(input logic [1:0] a, input bit wr, input logic [7:0] d);
        @(posedge clk);
        #1;
        i_Psel = 1'b1; i_Penable = 1'b0; i_Paddr = a; i_Pwrite = wr; i_Pwdata = d;
        @(posedge clk);
        #1;
        i_Penable = 1'b1;
        wait_ready(wr ? "apb_write_ready" : "apb_read_ready");
        @(posedge clk);
        #1;
        i_Psel = 1'b0; i_Penable = 1'b0;
    endtask

    task automatic apb_write(input logic [1:0] a, input logic [7:0] d);
        if (a == 2'd0) tx_q.push_back(d);
        apb_xfer(a, 1'b1, d);
    endtask

    task automatic push_rd(input string name, input logic [7:0] exp);
        rd_exp_t e;
        e.name = name;
        e.exp  = exp;
        rd_q.push_back(e);
    endtask

    task automatic apb_read(input logic [1:0] a, input string name, input logic [7:0] exp);
        push_rd(name, exp);
        apb_xfer(a, 1'b0, 8'h00);
    endtask

    task automatic rx_inject(input logic [7:0] b);
        @(posedge clk);
        #1;
        i_Rx_DV = 1'b1; i_Rx_Byte = b;
        if (rx_en_model) begin
            if (rx_model.size() < FD) rx_model.push_back(b);
            else ovr_model = 1'b1;
        end
        @(posedge clk);
        #1;
        i_Rx_DV = 1'b0;
    endtask

    task automatic wait_tx_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx_done_cnt == tx_launch_cnt && tx_q.size() == 0 && !o_Tx_DV) return;
        end
        timeout_fail("tx_idle");
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         cnt;
        rst_n = 1'b0;
        i_Paddr = 2'd0; i_Psel = 1'b0; i_Penable = 1'b0; i_Pwrite = 1'b0; i_Pwdata = 8'h00;
        i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00;
        #12;
        check("rst_pready", o_Pready, 1'b0);
        check("rst_prdata", o_Prdata, 8'h00);
        check("rst_tx_dv", o_Tx_DV, 1'b0);
        check("rst_tx_byte", o_Tx_Byte, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        apb_read(2'd1, "rst_status", 8'h06);
        apb_read(2'd2, "rst_ctrl", 8'h03);
        apb_read(2'd3, "clr_read", 8'h00);

        // Single frame: launch latency and busy flag.
        tx_block = 1'b1;
        apb_write(2'd0, 8'h53);
        @(negedge clk);
        check("tx_latency_dv", o_Tx_DV, 1'b1);
        check("tx_latency_byte", o_Tx_Byte, 8'h53);
        apb_read(2'd1, "status_busy", exp_status(1'b0, 1'b1, 1'b1));
        tx_block = 1'b0;
        wait_tx_idle();
        apb_read(2'd1, "status_idle", exp_status(1'b0, 1'b1, 1'b0));

        // Fill the TX FIFO behind a busy core, then stall on the sixth byte.
        tx_block = 1'b1;
        for (int i = 1; i <= 5; i++) apb_write(2'd0, 8'(i));
        apb_read(2'd1, "status_tx_full", exp_status(1'b1, 1'b0, 1'b1));
        fork
            apb_write(2'd0, 8'h06);
            begin
                repeat (5) @(negedge clk);
                check("tx_full_stall", o_Pready, 1'b0);
                tx_block = 1'b0;
            end
        join
        wait_tx_idle();

        // tx_en=0 blocks launching; re-enabling releases the queued byte.
        apb_write(2'd2, 8'h02);
        apb_write(2'd0, 8'h77);
        cnt = tx_launch_cnt;
        repeat (6) @(negedge clk);
        check("tx_en_block", tx_launch_cnt, cnt);
        apb_read(2'd1, "status_tx_pending", exp_status(1'b0, 1'b0, 1'b0));
        apb_read(2'd2, "ctrl_readback", 8'h02);
        apb_write(2'd1, 8'hFF);
        apb_write(2'd2, 8'h03);
        wait_tx_idle();

        // Random TX traffic with random frame lengths.
        repeat (12) begin
            tx_hold = $urandom_range(0, 4);
            b = 8'($urandom);
            apb_write(2'd0, b);
        end
        wait_tx_idle();

        // Blocking DATA read released by an incoming byte.
        fork
            apb_read(2'd0, "rx_block_rd", 8'h53);
            begin
                repeat (4) @(negedge clk);
                check("rx_empty_stall", o_Pready, 1'b0);
                rx_inject(8'h53);
                @(negedge clk);
                check("rx_ready_latency", o_Pready, 1'b1);
            end
        join
        void'(rx_model.pop_front());
        apb_read(2'd1, "status_rx_drained", exp_status(1'b0, 1'b1, 1'b0));

        // Overrun: fifth byte dropped, then sticky flag cleared by CLR.
        repeat (5) rx_inject(8'($urandom));
        apb_read(2'd1, "status_overrun", exp_status(1'b0, 1'b1, 1'b0));
        repeat (4) apb_read(2'd0, "rx_fifo_order", rx_model.pop_front());
        apb_write(2'd3, 8'h10);
        ovr_model = 1'b0;
        apb_read(2'd1, "status_ovr_clr", exp_status(1'b0, 1'b1, 1'b0));

        // rx_en=0 ignores incoming bytes without flagging overrun.
        apb_write(2'd2, 8'h01);
        rx_en_model = 1'b0;
        rx_inject(8'hA7);
        apb_read(2'd1, "status_rx_dis", exp_status(1'b0, 1'b1, 1'b0));
        apb_write(2'd2, 8'h03);
        rx_en_model = 1'b1;

        // Random interleaving of RX arrivals and DATA reads.
        repeat (16) begin
            if ($urandom_range(0, 1) == 1 && rx_model.size() > 0)
                apb_read(2'd0, "rx_rand", rx_model.pop_front());
            else
                rx_inject(8'($urandom));
        end
        apb_read(2'd1, "status_rx_rand", exp_status(1'b0, 1'b1, 1'b0));
        while (rx_model.size() > 0) apb_read(2'd0, "rx_rand_drain", rx_model.pop_front());
        apb_write(2'd3, 8'h10);
        ovr_model = 1'b0;

        // Full RX FIFO: read and arrival on the same edge, no overrun.
        repeat (FD) rx_inject(8'($urandom));
        @(posedge clk);
        #1;
        i_Psel = 1'b1; i_Penable = 1'b0; i_Paddr = 2'd0; i_Pwrite = 1'b0;
        @(posedge clk);
        #1;
        i_Penable = 1'b1;
        b = 8'($urandom);
        push_rd("rx_simul_rd", rx_model.pop_front());
        rx_model.push_back(b);
        i_Rx_DV = 1'b1; i_Rx_Byte = b;
        @(posedge clk);
        #1;
        i_Psel = 1'b0; i_Penable = 1'b0; i_Rx_DV = 1'b0;
        apb_read(2'd1, "status_simul", exp_status(1'b0, 1'b1, 1'b0));
        while (rx_model.size() > 0) apb_read(2'd0, "rx_simul_order", rx_model.pop_front());

        // Reset in the middle of a frame with RX data queued.
        tx_block = 1'b1;
        apb_write(2'd0, 8'hA5);
        rx_inject(8'h11);
        rx_inject(8'h22);
        @(posedge clk);
        #1;
        epoch++;
        rst_n = 1'b0;
        #1;
        check("midrst_tx_dv", o_Tx_DV, 1'b0);
        check("midrst_tx_byte", o_Tx_Byte, 8'h00);
        check("midrst_pready", o_Pready, 1'b0);
        check("midrst_prdata", o_Prdata, 8'h00);
        rx_model.delete();
        tx_q.delete();
        ovr_model = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = tx_launch_cnt;
        tx_block = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_launch", tx_launch_cnt, cnt);
        apb_read(2'd1, "midrst_status", 8'h06);
        apb_read(2'd2, "midrst_ctrl", 8'h03);

        repeat (4) @(negedge clk);
        check("rd_queue_empty", rd_q.size(), 0);
        check("tx_queue_empty", tx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
